// File: rtl/ctrl_datapath_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ctrl_datapath_if                                                 |
// | Brief    : control/operand inputs and result-FIFO valid/ready bus           |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface ctrl_datapath_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  logic [6:0]               ctrl;
  logic [W-1:0]             data_in;
  logic                     in_valid;
  logic [W-1:0]             acc;
  logic [W-1:0]             out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   fifo_cnt;
  logic                     drop_flag;
  logic                     ovf_flag;

  modport master (
    output ctrl, data_in, in_valid, out_ready,
    input  acc, out_data, out_valid, fifo_cnt, drop_flag, ovf_flag
  );

  modport slave (
    input  ctrl, data_in, in_valid, out_ready,
    output acc, out_data, out_valid, fifo_cnt, drop_flag, ovf_flag
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ctrl_datapath                                                    |
// | Brief    : accumulator micro-op datapath with result FIFO and sticky flags; |
// |            optional DP_SATURATE_EN makes the accumulator saturate.          |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ctrl_datapath #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  ctrl_datapath_if.slave bus
);
  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_acc;
  logic [W-1:0]      r_mem [DEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_cnt;
  logic              r_drop;
  logic              r_ovf;

  logic              w_ld_a, w_ld_b, w_add, w_sub, w_shl, w_store, w_clr;
  logic [W+1:0]      w_t;
  logic [W+2:0]      w_n;
  logic              w_ovf;
  logic [W-1:0]      w_acc_nxt;
  logic              w_full, w_empty, w_pop, w_push;

  assign {w_clr, w_store, w_shl, w_sub, w_add, w_ld_b, w_ld_a} = bus.ctrl;

  // W+2 bits hold acc+A-B exactly; the extra top bit of w_n keeps the sign across SHL
  assign w_t   = {2'b00, r_acc}
               + (w_add ? {2'b00, r_a} : '0)
               - (w_sub ? {2'b00, r_b} : '0);
  assign w_n   = w_shl ? {w_t, 1'b0} : {w_t[W+1], w_t};
  assign w_ovf = |w_n[W+2:W];

`ifdef DP_SATURATE_EN
  always_comb begin
    w_acc_nxt = w_n[W-1:0];
    if (w_n[W+2])
      w_acc_nxt = '0;
    else if (|w_n[W+1:W])
      w_acc_nxt = '1;
  end
`else
  assign w_acc_nxt = w_n[W-1:0];
`endif

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == c_DEPTH);
  assign w_pop   = !w_empty && bus.out_ready;
  assign w_push  = w_store && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_drop   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_ld_a && bus.in_valid) r_a <= bus.data_in;
      if (w_ld_b && bus.in_valid) r_b <= bus.data_in;
      r_acc <= w_clr ? '0 : w_acc_nxt;

      if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + c_CW'(1);
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - c_CW'(1);

      // Clear takes priority over any flag set in the same cycle
      if (w_clr)
        r_drop <= 1'b0;
      else if (w_store && !w_push)
        r_drop <= 1'b1;
      if (w_clr)
        r_ovf <= 1'b0;
      else if (w_ovf)
        r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_acc;
  end

  assign bus.acc       = r_acc;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.fifo_cnt  = r_cnt;
  assign bus.drop_flag = r_drop;
  assign bus.ovf_flag  = r_ovf;
endmodule
`default_nettype wire
